// File: rtl/ftch_dec_pkg.sv
// rtl/ftch_dec_pkg.sv - shared packet type and default sizing for the fetch-to-decode queue
package ftch_dec_pkg;

  localparam int LANES_DEF = 2;
  localparam int DEPTH_DEF = 8;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] data;
  } ftch_dec_pkt_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ftch_dec_lane_cnt.sv
// rtl/ftch_dec_lane_cnt.sv - thermometer lane mask to count, with legality flag
module ftch_dec_lane_cnt #(
  parameter  int LANES = 2,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] mask,
  output logic [CW-1:0]    cnt,
  output logic             thermo
);

  always_comb begin
    cnt    = '0;
    thermo = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) cnt = cnt + CW'(1);
    end
    // A set bit above a clear bit breaks the lane-0-first packing.
    for (int i = 1; i < LANES; i++) begin
      if (mask[i] && !mask[i-1]) thermo = 1'b0;
    end
  end

endmodule

// File: rtl/ftch_dec_queue.sv
// rtl/ftch_dec_queue.sv - multi-lane in-order fetch-to-decode packet queue
module ftch_dec_queue
  import ftch_dec_pkg::*;
#(
  parameter  int LANES = LANES_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic [LANES-1:0]          ftch_dec_vld,
  input  ftch_dec_pkt_t [LANES-1:0] ftch_dec_pkt,
  output logic                      ftch_dec_rdy,
  output logic [LANES-1:0]          dec_vld,
  output ftch_dec_pkt_t [LANES-1:0] dec_pkt,
  input  logic [LANES-1:0]          dec_rdy,
  output logic [CW-1:0]             count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(LANES + 1);

  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  space;
  logic [LW-1:0]  vld_cnt;
  logic [LW-1:0]  enq_cnt;
  logic [LW-1:0]  deq_cnt;
  logic           enq_thermo;
  logic           deq_thermo;
  logic [LANES-1:0] deq_mask;
  ftch_dec_pkt_t  mem [DEPTH];

  // Ready looks only at registered occupancy so it never depends on dec_rdy.
  assign space        = CW'(DEPTH) - count_q;
  assign ftch_dec_rdy = (space >= CW'(LANES)) && !flush;
  assign count        = count_q;

  always_comb begin
    dec_vld = '0;
    dec_pkt = '0;
    for (int i = 0; i < LANES; i++) begin
      dec_vld[i] = (count_q > CW'(i)) && !flush;
      dec_pkt[i] = mem[rd_ptr + PW'(i)];
    end
  end

  assign deq_mask = dec_vld & dec_rdy;
  assign enq_cnt  = ftch_dec_rdy ? vld_cnt : '0;

  ftch_dec_lane_cnt #(.LANES(LANES)) u_enq_cnt (
    .mask   (ftch_dec_vld),
    .cnt    (vld_cnt),
    .thermo (enq_thermo)
  );

  ftch_dec_lane_cnt #(.LANES(LANES)) u_deq_cnt (
    .mask   (deq_mask),
    .cnt    (deq_cnt),
    .thermo (deq_thermo)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(enq_cnt);
      rd_ptr  <= rd_ptr + PW'(deq_cnt);
      count_q <= count_q + CW'(enq_cnt) - CW'(deq_cnt);
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (ftch_dec_rdy) begin
      for (int i = 0; i < LANES; i++) begin
        if (ftch_dec_vld[i]) mem[wr_ptr + PW'(i)] <= ftch_dec_pkt[i];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (is_pow2(DEPTH) && (DEPTH >= 2 * LANES))
        else $error("ftch_dec_queue: illegal DEPTH/LANES combination");
      assert (enq_thermo)
        else $error("ftch_dec_queue: ftch_dec_vld is not a thermometer mask");
      assert (deq_thermo)
        else $error("ftch_dec_queue: dec_rdy is not a thermometer mask");
    end
  end
`endif

endmodule

// File: tb/tb_ftch_dec_queue.sv
// tb/tb_ftch_dec_queue.sv - directed table-driven bench for ftch_dec_queue
module tb_ftch_dec_queue;
  import ftch_dec_pkg::*;

  logic             clk;
  logic             resetn;
  logic             flush;
  logic [1:0]       ftch_dec_vld;
  ftch_dec_pkt_t [1:0] ftch_dec_pkt;
  logic             ftch_dec_rdy;
  logic [1:0]       dec_vld;
  ftch_dec_pkt_t [1:0] dec_pkt;
  logic [1:0]       dec_rdy;
  logic [3:0]       count;

  int n_chk  = 0;
  int n_fail = 0;

  ftch_dec_queue #(.LANES(2), .DEPTH(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .ftch_dec_vld (ftch_dec_vld),
    .ftch_dec_pkt (ftch_dec_pkt),
    .ftch_dec_rdy (ftch_dec_rdy),
    .dec_vld      (dec_vld),
    .dec_pkt      (dec_pkt),
    .dec_rdy      (dec_rdy),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       fl;
    logic [1:0] vld;
    logic [7:0] a, b;
    logic [1:0] rdy;
    logic [3:0] e_cnt;
    logic [1:0] e_dvld;
    logic       e_frdy;
    logic [7:0] e_p0, e_p1;
  } vec_t;

  function automatic ftch_dec_pkt_t mkpkt(input logic [7:0] id);
    ftch_dec_pkt_t p;
    p.id   = id;
    p.data = {id, ~id};
    return p;
  endfunction

  function automatic vec_t mk(input logic fl, input logic [1:0] vld, input logic [7:0] a, b,
                              input logic [1:0] rdy, input logic [3:0] c, input logic [1:0] dv,
                              input logic fr, input logic [7:0] p0, p1);
    vec_t v;
    v.fl = fl; v.vld = vld; v.a = a; v.b = b; v.rdy = rdy;
    v.e_cnt = c; v.e_dvld = dv; v.e_frdy = fr; v.e_p0 = p0; v.e_p1 = p1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [1:0] vld, input logic [7:0] a, b,
                       input logic [1:0] rdy);
    flush           = fl;
    ftch_dec_vld    = vld;
    ftch_dec_pkt[0] = mkpkt(a);
    ftch_dec_pkt[1] = mkpkt(b);
    dec_rdy         = rdy;
  endtask

  vec_t tbl [15];
  vec_t v;
  logic [7:0] q [$];
  int sent, rcvd;
  ftch_dec_pkt_t exp_p;

  initial begin
    tbl[0]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 1, 8'h00, 8'h00);
    tbl[1]  = mk(0, 2'b11, 8'h01, 8'h02, 2'b00, 0, 2'b00, 1, 8'h00, 8'h00);
    tbl[2]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 2, 2'b11, 1, 8'h01, 8'h02);
    tbl[3]  = mk(0, 2'b11, 8'h03, 8'h04, 2'b00, 2, 2'b11, 1, 8'h01, 8'h02);
    tbl[4]  = mk(0, 2'b11, 8'h05, 8'h06, 2'b00, 4, 2'b11, 1, 8'h01, 8'h02);
    tbl[5]  = mk(0, 2'b11, 8'h07, 8'h08, 2'b00, 6, 2'b11, 1, 8'h01, 8'h02);
    tbl[6]  = mk(0, 2'b11, 8'h09, 8'h0A, 2'b00, 8, 2'b11, 0, 8'h01, 8'h02);
    tbl[7]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 8, 2'b11, 0, 8'h01, 8'h02);
    tbl[8]  = mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 8, 2'b11, 0, 8'h01, 8'h02);
    tbl[9]  = mk(0, 2'b01, 8'h0B, 8'h00, 2'b11, 6, 2'b11, 1, 8'h03, 8'h04);
    tbl[10] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 5, 2'b11, 1, 8'h05, 8'h06);
    tbl[11] = mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 5, 2'b11, 1, 8'h05, 8'h06);
    tbl[12] = mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 3, 2'b11, 1, 8'h07, 8'h08);
    tbl[13] = mk(0, 2'b00, 8'h00, 8'h00, 2'b11, 1, 2'b01, 1, 8'h0B, 8'h00);
    tbl[14] = mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 1, 8'h00, 8'h00);

    resetn = 1'b0;
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00);
    repeat (2) @(negedge clk);
    #1;
    chk("reset count", count, 0);
    chk("reset dec_vld", dec_vld, 0);
    chk("reset ftch_dec_rdy", ftch_dec_rdy, 1);
    @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < 15; k++) begin
      v = tbl[k];
      drive(v.fl, v.vld, v.a, v.b, v.rdy);
      #1;
      chk($sformatf("v%0d count", k), count, v.e_cnt);
      chk($sformatf("v%0d dec_vld", k), dec_vld, v.e_dvld);
      chk($sformatf("v%0d ftch_dec_rdy", k), ftch_dec_rdy, v.e_frdy);
      if (v.e_dvld[0]) chk($sformatf("v%0d dec_pkt0", k), dec_pkt[0], mkpkt(v.e_p0));
      if (v.e_dvld[1]) chk($sformatf("v%0d dec_pkt1", k), dec_pkt[1], mkpkt(v.e_p1));
      @(negedge clk);
    end

    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 200 && (sent < 20 || q.size() > 0); cyc++) begin
      drive(0, (sent < 20) ? 2'b11 : 2'b00, 8'(8'h80 + sent), 8'(8'h81 + sent),
            cyc[0] ? 2'b11 : 2'b01);
      #1;
      chk($sformatf("stream c%0d count", cyc), count, q.size());
      chk($sformatf("stream c%0d dec_vld", cyc), dec_vld, {q.size() > 1, q.size() > 0});
      for (int i = 0; i < 2; i++) begin
        if (dec_vld[i] && dec_rdy[i]) begin
          exp_p = (q.size() > 0) ? mkpkt(q.pop_front()) : mkpkt(8'hFF);
          chk($sformatf("stream c%0d lane%0d pkt", cyc, i), dec_pkt[i], exp_p);
          rcvd++;
        end
      end
      if (ftch_dec_rdy && sent < 20) begin
        q.push_back(8'(8'h80 + sent));
        q.push_back(8'(8'h81 + sent));
        sent += 2;
      end
      @(negedge clk);
    end
    chk("stream sent", sent, 20);
    chk("stream received", rcvd, 20);

    drive(0, 2'b11, 8'h40, 8'h41, 2'b00);
    @(negedge clk);
    drive(0, 2'b11, 8'h42, 8'h43, 2'b00);
    @(negedge clk);
    drive(1, 2'b11, 8'h44, 8'h45, 2'b11);
    #1;
    chk("flush pre count", count, 4);
    chk("flush dec_vld", dec_vld, 0);
    chk("flush ftch_dec_rdy", ftch_dec_rdy, 0);
    @(negedge clk);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b11);
    #1;
    chk("post flush count", count, 0);
    chk("post flush dec_vld", dec_vld, 0);
    chk("post flush ftch_dec_rdy", ftch_dec_rdy, 1);
    @(negedge clk);
    drive(0, 2'b11, 8'h50, 8'h51, 2'b00);
    @(negedge clk);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00);
    #1;
    chk("refill count", count, 2);
    chk("refill dec_vld", dec_vld, 2'b11);
    chk("refill pkt0", dec_pkt[0], mkpkt(8'h50));
    chk("refill pkt1", dec_pkt[1], mkpkt(8'h51));
    @(negedge clk);
    drive(0, 2'b01, 8'h52, 8'h00, 2'b00);
    @(negedge clk);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00);
    #1;
    chk("pre reset count", count, 3);
    #2;
    resetn = 1'b0;
    #1;
    chk("async reset count", count, 0);
    chk("async reset dec_vld", dec_vld, 0);
    chk("async reset ftch_dec_rdy", ftch_dec_rdy, 1);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 2'b11, 8'h60, 8'h61, 2'b00);
    @(negedge clk);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00);
    #1;
    chk("first enq count", count, 2);
    chk("first enq dec_vld", dec_vld, 2'b11);
    chk("first enq pkt0", dec_pkt[0], mkpkt(8'h60));
    chk("first enq pkt1", dec_pkt[1], mkpkt(8'h61));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
